// File: rtl/select_fd.sv
// select_fd: final quotient-selection stage of the Newton-Raphson divider.
// Compares the back-multiplied product E*Db against the aligned dividend to
// decide whether the quotient approximation E is exact, one ulp too large,
// or short by less than one ulp, and registers the corrected significand
// together with a sticky bit for the rounder. One pipeline stage.
module select_fd (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [57:0]    Da,
    input  logic [57:0]    Db,
    input  logic [114:0]   Eb,
    input  logic           db,
    input  logic [54:0]    E,
    output logic [56:0]    fd
);

    // Unit in the last place for single precision: bit 29 of E.
    localparam logic [54:0] ULP_SINGLE = 55'h0000_0000_2000_0000;
    localparam logic [54:0] ULP_DOUBLE = 55'h0000_0000_0000_0001;

    // Result classes from the magnitude comparison.
    localparam logic [1:0] CMP_LT = 2'b00;
    localparam logic [1:0] CMP_EQ = 2'b01;
    localparam logic [1:0] CMP_GT = 2'b10;

    // Equal / greater flags of an unsigned 115-bit magnitude compare.
    function automatic logic [1:0] mag_cmp(input logic [114:0] lhs,
                                           input logic [114:0] rhs);
        logic [1:0] res;
        if (lhs == rhs) begin
            res = CMP_EQ;
        end else if (lhs > rhs) begin
            res = CMP_GT;
        end else begin
            res = CMP_LT;
        end
        return res;
    endfunction

    logic [54:0]  em_s;      // precision-masked quotient approximation
    logic [54:0]  ulp_s;     // ulp of the selected precision
    logic [54:0]  em_dec_s;  // Em - ulp, wraps modulo 2^55
    logic [114:0] a_s;       // dividend aligned to the Eb binary point
    logic [1:0]   cmp_s;     // comparison class of Eb against A
    logic [54:0]  eadj_s;    // corrected quotient significand
    logic         sticky_s;  // nonzero remainder indicator
    logic [56:0]  fd_d;
    logic [56:0]  fd_q;

    // Db only travels alongside the datapath for alignment/debug; it has
    // no say in the selection, so it is reduced here and left unconnected.
    logic         unused_db_s;
    assign unused_db_s = ^Db;

    // Mask E to the selected precision and pick the matching ulp.
    always_comb begin
        em_s  = E;
        ulp_s = ULP_DOUBLE;
        if (db) begin
            em_s  = E;
            ulp_s = ULP_DOUBLE;
        end else begin
            em_s  = {E[54:29], 29'b0};
            ulp_s = ULP_SINGLE;
        end
    end

    // Decrement by one ulp and classify Eb against the aligned dividend.
    always_comb begin
        a_s      = {Da, 57'b0};
        em_dec_s = em_s - ulp_s;
        cmp_s    = mag_cmp(Eb, a_s);
    end

    // Select the corrected quotient and sticky from the comparison class.
    always_comb begin
        eadj_s   = em_s;
        sticky_s = 1'b1;
        case (cmp_s)
            CMP_EQ: begin
                eadj_s   = em_s;
                sticky_s = 1'b0;
            end
            CMP_GT: begin
                eadj_s   = em_dec_s;
                sticky_s = 1'b1;
            end
            CMP_LT: begin
                eadj_s   = em_s;
                sticky_s = 1'b1;
            end
            default: begin
                eadj_s   = em_s;
                sticky_s = 1'b1;
            end
        endcase
        fd_d = {1'b0, eadj_s, sticky_s};
    end

    // Output pipeline register; async reset clears any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fd_q <= 57'h0;
        end else begin
            fd_q <= fd_d;
        end
    end

    assign fd = fd_q;

endmodule

// File: tb/tb_select_fd.sv
// Self-checking bench for select_fd: directed vectors plus randomized
// back-to-back traffic compared against an arithmetic reference model.
module tb_select_fd;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b1;
    logic [57:0]    Da    = 58'h0;
    logic [57:0]    Db    = 58'h0;
    logic [114:0]   Eb    = 115'h0;
    logic           db    = 1'b1;
    logic [54:0]    E     = 55'h0;
    logic [56:0]    fd;

    int tests_run = 0;
    int tests_failed = 0;

    select_fd dut (
        .clk   (clk),
        .rst_n (rst_n),
        .Da    (Da),
        .Db    (Db),
        .Eb    (Eb),
        .db    (db),
        .E     (E),
        .fd    (fd)
    );

    always #5 clk = ~clk;

    // Reference: quotient selection from the arithmetic rules.
    function automatic logic [56:0] ref_fd(input logic [57:0] da,
                                           input logic [114:0] eb,
                                           input logic dbl,
                                           input logic [54:0] e);
        logic [54:0]  em;
        logic [54:0]  ulp;
        logic [114:0] a;
        if (dbl) begin
            em  = e;
            ulp = 55'd1;
        end else begin
            em  = (e >> 29) << 29;
            ulp = 55'd536870912;
        end
        a = 115'(da) << 57;
        if (eb == a)      return {1'b0, em, 1'b0};
        else if (eb > a)  return {1'b0, em - ulp, 1'b1};
        else              return {1'b0, em, 1'b1};
    endfunction

    function automatic logic [57:0] rnd58();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[57:0];
    endfunction

    function automatic logic [54:0] rnd55();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[54:0];
    endfunction

    function automatic logic [114:0] rnd115();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[114:0];
    endfunction

    task automatic drive(input logic [57:0] da, input logic [57:0] dbv,
                         input logic [114:0] eb, input logic dbl,
                         input logic [54:0] e);
        Da = da; Db = dbv; Eb = eb; db = dbl; E = e;
    endtask

    // Apply one vector at a negedge, capture at posedge, check at the next negedge.
    task automatic one_shot(input string name, input logic [57:0] da,
                            input logic [114:0] eb, input logic dbl,
                            input logic [54:0] e, input logic [56:0] exp_v);
        @(negedge clk);
        drive(da, 58'h2A, eb, dbl, e);
        @(negedge clk);
        tests_run++;
        if (fd !== exp_v) begin
            tests_failed++;
            $display("FAIL %s: fd=%h expected %h", name, fd, exp_v);
        end
    endtask

    task automatic test_reset();
        drive(58'h3FFFFFFF, 58'h1, 115'h12345, 1'b1, 55'h1555555555555);
        #1 rst_n = 1'b0;
        #1;
        tests_run++;
        if (fd !== 57'h0) begin
            tests_failed++;
            $display("FAIL reset_async: fd=%h expected 0", fd);
        end
        @(negedge clk);
        tests_run++;
        if (fd !== 57'h0) begin
            tests_failed++;
            $display("FAIL reset_held: fd=%h expected 0", fd);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (fd !== ref_fd(Da, Eb, db, E)) begin
            tests_failed++;
            $display("FAIL reset_release: fd=%h expected %h", fd, ref_fd(Da, Eb, db, E));
        end
    endtask

    task automatic test_double();
        logic [114:0] two57;
        two57 = 115'd1 << 57;
        one_shot("dbl_exact", 58'd1, two57,         1'b1, 55'h10, 57'h20);
        one_shot("dbl_large", 58'd1, two57 + 115'd1, 1'b1, 55'h10, 57'h1F);
        one_shot("dbl_small", 58'd1, two57 - 115'd1, 1'b1, 55'h10, 57'h21);
        one_shot("dbl_wrap",  58'd1, two57 + 115'd1, 1'b1, 55'h0,
                 {1'b0, 55'h7FFFFFFFFFFFFF, 1'b1});
    endtask

    task automatic test_single();
        logic [114:0] two57;
        two57 = 115'd1 << 57;
        one_shot("sgl_exact", 58'd1, two57,           1'b0, 55'h200000FF, 57'h40000000);
        one_shot("sgl_large", 58'd1, two57 + 115'd1,  1'b0, 55'h200000FF, 57'h1);
        one_shot("sgl_small", 58'd1, two57 - 115'd1,  1'b0, 55'h200000FF, 57'h40000001);
        one_shot("sgl_wrap",  58'd1, two57 + 115'd1,  1'b0, 55'h1FFFFFFF,
                 {1'b0, 55'h7FFFFFE0000000, 1'b1});
    endtask

    // Continuous traffic, db toggling, each result checked one cycle later.
    task automatic test_back_to_back();
        logic [56:0]  exp_q[$];
        logic [57:0]  da, dbv;
        logic [114:0] eb;
        logic [54:0]  e, em;
        logic         dbl;
        logic [56:0]  exp_v;
        logic [114:0] two57;
        two57 = 115'd1 << 57;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                tests_run++;
                if (fd !== exp_v) begin
                    tests_failed++;
                    $display("FAIL b2b[%0d]: fd=%h expected %h", i, fd, exp_v);
                end
            end
            dbl = i[0];
            dbv = rnd58();
            e   = rnd55();
            case (i % 5)
                0: begin da = 58'd1; eb = two57; e = dbl ? 55'h10 : 55'h200000FF; end
                1: begin da = 58'd1; eb = two57 + 115'd1; e = dbl ? 55'h10 : 55'h200000FF; end
                2: begin
                    em = dbl ? e : ((e >> 29) << 29);
                    eb = 115'(em) * 115'(dbv);
                    da = eb[114:57];
                end
                3: begin
                    em = dbl ? e : ((e >> 29) << 29);
                    eb = 115'(em) * 115'(dbv);
                    da = eb[114:57] + 58'd1;
                end
                default: begin
                    da = rnd58();
                    eb = rnd115();
                end
            endcase
            drive(da, dbv, eb, dbl, e);
            exp_q.push_back(ref_fd(da, eb, dbl, e));
        end
        @(negedge clk);
        exp_v = exp_q.pop_front();
        tests_run++;
        if (fd !== exp_v) begin
            tests_failed++;
            $display("FAIL b2b_last: fd=%h expected %h", fd, exp_v);
        end
    endtask

    // Only Db varies: fd must stay at the value set by the other inputs.
    task automatic test_db_only();
        logic [56:0] exp_v;
        @(negedge clk);
        drive(rnd58(), rnd58(), rnd115(), 1'b1, rnd55());
        exp_v = ref_fd(Da, Eb, db, E);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests_run++;
            if (fd !== exp_v) begin
                tests_failed++;
                $display("FAIL db_only[%0d]: fd=%h expected %h", i, fd, exp_v);
            end
            Db = rnd58();
        end
    endtask

    // Mid-stream reset discards the pending result; mid-cycle input changes are invisible.
    task automatic test_midstream();
        logic [56:0] exp_v;
        @(negedge clk);
        drive(58'd1, 58'h5, 115'd1 << 57, 1'b1, 55'h10);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (fd !== 57'h0) begin
            tests_failed++;
            $display("FAIL midreset: fd=%h expected 0", fd);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(58'd1, 58'h5, 115'd1 << 57, 1'b1, 55'h10);
        exp_v = 57'h20;
        @(posedge clk);
        #2;
        drive(58'd1, 58'h5, (115'd1 << 57) + 115'd1, 1'b0, 55'h3);
        #1;
        tests_run++;
        if (fd !== exp_v) begin
            tests_failed++;
            $display("FAIL hold_between_edges: fd=%h expected %h", fd, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_double();
        test_single();
        test_back_to_back();
        test_db_only();
        test_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Absolute time bound so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/select_fd.md
# select_fd

Final quotient-selection stage of the Newton–Raphson divider in the multiplier/divider datapath. It receives the dividend significand, the divisor significand, the quotient approximation E and the product E·b from the multiplier. It decides whether E is exact, too large or too small, and emits the corrected quotient significand with a sticky bit for the rounder. Output is registered, so the block adds one pipeline stage.

## Interface
- No parameters. All widths are fixed.
- Clocking: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- Da  in  58  dividend significand, fixed point, binary point aligned to Eb[114:57].
- Db  in  58  divisor significand. Carried for alignment and debug only; not used in selection.
- Eb  in  115  product E·Db from the multiplier, computed with the precision-masked E.
- db  in  1  precision select: 1 = double (ulp at E bit 0), 0 = single (ulp at E bit 29).
- E  in  55  quotient approximation. Guaranteed error is below 1 ulp of the selected precision.
- fd  out  57  corrected quotient: fd[56]=0, fd[55:1]=Eadj, fd[0]=sticky.

## Operation
- Precision masking:
  - Em = E when db=1.
  - Em = {E[54:29], 29'b0} when db=0.
  - ulp = 1 when db=1; ulp = 2^29 when db=0.
- Reference value: A = {Da, 57'b0} (115 bits, unsigned).
- Unsigned 115-bit compare of Eb against A selects the result:
  - Eb == A: exact quotient. Eadj = Em, sticky = 0.
  - Eb > A: E too large. Eadj = Em − ulp (mod 2^55), sticky = 1.
  - Eb < A: E too small but within 1 ulp. Eadj = Em, sticky = 1.
- In single mode, fd[29:1] is always 0 and only fd[55:30] and fd[0] carry information.
- Eb is not recomputed internally. The caller guarantees Eb = Em·Db at the stated alignment. With inconsistent inputs, the block still applies the rules above literally: Em − ulp wraps modulo 2^55, with no flag.
- Db does not influence fd.
- Datapath:
  - Combinational: masking, the 115-bit magnitude comparator (eq/gt), the 55-bit decrementer with ulp selected by db, and the result mux.
  - A single 57-bit register drives fd.

## Timing
- Latency: 1 cycle. Inputs sampled on rising edge N drive fd after edge N.
- No handshake. A new input set may be applied every cycle; throughput is 1 per cycle.
- Reset: rst_n low forces fd = 57'h0 immediately (asynchronous), held while low.
- Release of rst_n takes effect synchronously. The first capture is on the first rising edge with rst_n high.
- Reset asserted mid-stream discards the in-flight result. No other state exists.
- Inputs changing between edges have no effect on fd until the next edge. There are no combinational paths to the output.
- Switching db between cycles takes effect on the very next captured result. No mode latency.

## Test plan
- Reset: hold rst_n=0 with arbitrary inputs (Da=58'h3FFFFFFF, E=55'h1555555555555) -> fd = 0 before any clock edge. Release rst_n, apply a clock -> fd reflects inputs.
- Exact, double: db=1, Da=1, Eb=2^57, E=55'h10 -> one cycle later fd = 57'h20.
- E too large, double: db=1, Da=1, Eb=2^57+1, E=55'h10 -> fd = 57'h1F (Eadj=0xF, sticky=1).
- E too small, double: db=1, Da=1, Eb=2^57−1, E=55'h10 -> fd = 57'h21.
- Single mode:
  - db=0, Da=1, Eb=2^57, E=55'h200000FF -> fd = 57'h40000000 (low bits masked, sticky 0).
  - Same E with Eb=2^57+1 -> fd = 57'h1.
- Back-to-back: alternate db 0/1 each cycle with the vectors above, plus random E with Eb=E·Db·2^(57−k) consistent -> each fd matches the reference model exactly one cycle after its inputs; Db changes alone never alter fd.
